// File: rtl/nn_param_pkg.sv
// Shared definitions for the neuron parameter loader and readback paths:
// frame geometry, parameter byte order and the readback FSM state type.
package nn_param_pkg;

  localparam int NUM_PARAMS = 20;
  localparam int PARAM_W    = 8;

  // Byte order inside params_flat: four weights then the bias, per neuron
  localparam int IDX_W00 = 0;
  localparam int IDX_W01 = 1;
  localparam int IDX_W02 = 2;
  localparam int IDX_W03 = 3;
  localparam int IDX_B0  = 4;
  localparam int IDX_W10 = 5;
  localparam int IDX_W11 = 6;
  localparam int IDX_W12 = 7;
  localparam int IDX_W13 = 8;
  localparam int IDX_B1  = 9;
  localparam int IDX_W20 = 10;
  localparam int IDX_W21 = 11;
  localparam int IDX_W22 = 12;
  localparam int IDX_W23 = 13;
  localparam int IDX_B2  = 14;
  localparam int IDX_W30 = 15;
  localparam int IDX_W31 = 16;
  localparam int IDX_W32 = 17;
  localparam int IDX_W33 = 18;
  localparam int IDX_B3  = 19;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/param_checksum_acc.sv
// Running XOR of the parameter bytes as they are transferred; clear wins over enable.
module param_checksum_acc #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] acc_o
);

  logic [W-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q ^ data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/param_readback_serializer.sv
// Snapshots the packed parameter set on start and streams it out byte by byte
// over a valid/ready port. Define PARAM_READBACK_CHECKSUM_EN to append an XOR checksum byte.
module param_readback_serializer #(
  parameter int NUM_PARAMS = nn_param_pkg::NUM_PARAMS,
  parameter int PARAM_W    = nn_param_pkg::PARAM_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [NUM_PARAMS*PARAM_W-1:0] params_flat,
  input  logic                          rd_ready,
  output logic [PARAM_W-1:0]            rd_data,
  output logic                          rd_valid,
  output logic                          busy,
  output logic                          done
);
  import nn_param_pkg::*;

`ifdef PARAM_READBACK_CHECKSUM_EN
  localparam int FRAME_LEN = NUM_PARAMS + 1;
`else
  localparam int FRAME_LEN = NUM_PARAMS;
`endif
  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_e                        state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [NUM_PARAMS*PARAM_W-1:0] snap_q, snap_d;
  logic                          accept;
  logic                          xfer;
  logic [PARAM_W-1:0]            cur_byte;
  logic [PARAM_W-1:0]            out_byte;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    accept  = 1'b0;
    xfer    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = SEND;
          idx_d   = IDX_W'(IDX_W00);
          snap_d  = params_flat;
        end
      end
      SEND: begin
        if (rd_ready) begin
          xfer = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
    end
  end

  always_comb begin
    cur_byte = '0;
    for (int k = 0; k < NUM_PARAMS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_byte = snap_q[k*PARAM_W +: PARAM_W];
      end
    end
  end

`ifdef PARAM_READBACK_CHECKSUM_EN
  logic [PARAM_W-1:0] csum;
  logic               csum_en;

  // Only parameter bytes feed the sum, never the checksum byte itself
  assign csum_en = xfer && (idx_q < IDX_W'(NUM_PARAMS));

  param_checksum_acc #(
    .W (PARAM_W)
  ) u_csum (
    .clk_i  (clk),
    .rst_i  (reset),
    .clr_i  (accept),
    .en_i   (csum_en),
    .data_i (cur_byte),
    .acc_o  (csum)
  );

  assign out_byte = (idx_q == IDX_W'(NUM_PARAMS)) ? csum : cur_byte;
`else
  assign out_byte = cur_byte;
`endif

  assign rd_valid = (state_q == SEND);
  assign rd_data  = rd_valid ? out_byte : '0;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_param_readback_serializer.sv
// Directed bench for param_readback_serializer: table-driven basic frame plus
// hand-written backpressure, snapshot/ignored-start and mid-frame reset sequences.
module tb_param_readback_serializer;
  import nn_param_pkg::*;

  localparam int NP = NUM_PARAMS;
`ifdef PARAM_READBACK_CHECKSUM_EN
  localparam int FL = NP + 1;
`else
  localparam int FL = NP;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [NP*8-1:0]   params_flat;
  logic              rd_ready;
  logic [7:0]        rd_data;
  logic              rd_valid;
  logic              busy;
  logic              done;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_byte [FL];

  typedef struct {
    bit         ready;
    bit         valid;
    logic [7:0] data;
    bit         busy;
    bit         done;
  } vec_t;
  vec_t vecs[$];

  param_readback_serializer #(
    .NUM_PARAMS (NP),
    .PARAM_W    (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .params_flat (params_flat),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load_ramp();
    for (int k = 0; k < NP; k++) params_flat[k*8 +: 8] = 8'(k + 1);
  endtask

  // One frame with an optional stall window (cycles counted from the first
  // valid cycle) and optional disturbance: params overwritten and start pulsed
  // mid-frame and again in DONE.
  task automatic run_frame(input string tag, input int stall_lo, input int stall_hi,
                           input bit disturb);
    int got[$];
    int dones;
    dones = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < FL*2 + 12; c++) begin
      rd_ready = !(c >= stall_lo && c <= stall_hi);
      start    = disturb && (c == 2 || done);
      if (disturb && c == 2) params_flat = '1;
      if (c >= stall_lo && c <= stall_hi) begin
        chk({tag, "_hold_data"}, 32'(rd_data), 32'h02);
        chk({tag, "_hold_valid"}, 32'(rd_valid), 32'd1);
      end
      if (rd_valid && rd_ready) got.push_back(int'(rd_data));
      if (done) dones++;
      step();
    end
    start    = 1'b0;
    rd_ready = 1'b1;
    chk({tag, "_len"}, 32'(got.size()), 32'(FL));
    for (int k = 0; k < got.size() && k < FL; k++)
      chk($sformatf("%s_byte%0d", tag, k), 32'(got[k]), 32'(exp_byte[k]));
    chk({tag, "_dones"}, 32'(dones), 32'd1);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] x;
    reset       = 1'b1;
    start       = 1'b0;
    rd_ready    = 1'b1;
    params_flat = '0;
    load_ramp();

    x = 8'h00;
    for (int k = 0; k < NP; k++) begin
      exp_byte[k] = 8'(k + 1);
      x = x ^ 8'(k + 1);
    end
`ifdef PARAM_READBACK_CHECKSUM_EN
    exp_byte[NP] = x;
`endif

    for (int i = 0; i < FL; i++) vecs.push_back('{1'b1, 1'b1, exp_byte[i], 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 8'h00, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 1'b0});

    #12;
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_data",  32'(rd_data),  32'd0);
    chk("rst_busy",  32'(busy),     32'd0);
    chk("rst_done",  32'(done),     32'd0);
    @(negedge clk);
    reset = 1'b0;
    step();
    step();
    chk("idle_valid", 32'(rd_valid), 32'd0);
    chk("idle_busy",  32'(busy),     32'd0);

    // Basic frame, cycle-exact
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      rd_ready = vecs[i].ready;
      chk($sformatf("basic_valid%0d", i), 32'(rd_valid), 32'(vecs[i].valid));
      chk($sformatf("basic_data%0d", i),  32'(rd_data),  32'(vecs[i].data));
      chk($sformatf("basic_busy%0d", i),  32'(busy),     32'(vecs[i].busy));
      chk($sformatf("basic_done%0d", i),  32'(done),     32'(vecs[i].done));
      step();
    end

    run_frame("bp", 1, 3, 1'b0);
    run_frame("snap", -1, -1, 1'b1);
    load_ramp();

    // Reset in the middle of a frame
    start = 1'b1;
    step();
    start = 1'b0;
    rd_ready = 1'b1;
    repeat (5) step();
    chk("pre_rst_data", 32'(rd_data), 32'h06);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(rd_valid), 32'd0);
    chk("mid_rst_data",  32'(rd_data),  32'd0);
    chk("mid_rst_busy",  32'(busy),     32'd0);
    chk("mid_rst_done",  32'(done),     32'd0);
    step();
    reset = 1'b0;
    step();
    chk("post_rst_valid", 32'(rd_valid), 32'd0);
    chk("post_rst_busy",  32'(busy),     32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_valid", 32'(rd_valid), 32'd1);
    chk("restart_data",  32'(rd_data),  32'h01);
    repeat (FL + 3) step();
    chk("restart_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
